// File: rtl/ekf_stage_sequencer.sv
// Host-side initiator for the EKF core stage handshake: one PRD per odometry
// command, then ASSOC followed by UPD or NEW for each queued observation.
module ekf_stage_sequencer #(
  parameter int DW      = 32,
  parameter int FIFO_AW = 3,
  parameter int VAL_CYC = 2,
  parameter int TIMEOUT = 4096,
  parameter int LM_W    = 10
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            odo_val,
  output logic            odo_rdy,
  input  logic [DW-1:0]   odo_vlr,
  input  logic [DW-1:0]   odo_alpha,
  input  logic            obs_val,
  output logic            obs_rdy,
  input  logic [DW-1:0]   obs_rk,
  input  logic [DW-1:0]   obs_phi,
  output logic [2:0]      stage_val,
  input  logic [2:0]      stage_rdy,
  input  logic            assoc_new,
  output logic [DW-1:0]   vlr,
  output logic [DW-1:0]   alpha,
  output logic [DW-1:0]   rk,
  output logic [DW-1:0]   phi,
  output logic [LM_W-1:0] landmark_num,
  output logic            busy,
  output logic            timeout_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int VW    = $clog2(VAL_CYC + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [2:0] STG_IDLE  = 3'd0;
  localparam logic [2:0] STG_PRD   = 3'd1;
  localparam logic [2:0] STG_NEW   = 3'd2;
  localparam logic [2:0] STG_UPD   = 3'd3;
  localparam logic [2:0] STG_ASSOC = 3'd4;

  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [VW-1:0]    VAL_LAST = VW'(VAL_CYC - 1);
  localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_POP,
    S_PRD_ISSUE,
    S_PRD_WAIT,
    S_ASSOC_ISSUE,
    S_ASSOC_WAIT,
    S_UPD_ISSUE,
    S_UPD_WAIT,
    S_NEW_ISSUE,
    S_NEW_WAIT,
    S_ERR
  } state_t;

  state_t state, state_n;

  logic [2*DW-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic full, empty, push, pop;

  logic [VW-1:0] val_cnt;
  logic [TW-1:0] to_cnt;
  logic val_last, to_done, is_issue, is_wait, odo_hs;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign obs_rdy  = !full && !sys_rst;
  assign push     = obs_val && obs_rdy;
  assign pop      = (state == S_POP);
  assign odo_rdy  = (state == S_IDLE) && !sys_rst;
  assign odo_hs   = odo_val && odo_rdy;
  assign busy     = (state != S_IDLE);
  assign timeout_err = (state == S_ERR);
  assign val_last = (val_cnt == VAL_LAST);
  assign to_done  = (to_cnt == TO_LAST);
  assign is_issue = state inside {S_PRD_ISSUE, S_ASSOC_ISSUE, S_UPD_ISSUE, S_NEW_ISSUE};
  assign is_wait  = state inside {S_PRD_WAIT, S_ASSOC_WAIT, S_UPD_WAIT, S_NEW_WAIT};

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Odometry wins over queued observations; a completion is only honoured in WAIT.
  always_comb begin
    state_n   = state;
    stage_val = STG_IDLE;
    case (state)
      S_IDLE: begin
        if (odo_val)     state_n = S_PRD_ISSUE;
        else if (!empty) state_n = S_POP;
      end
      S_POP: state_n = S_ASSOC_ISSUE;
      S_PRD_ISSUE: begin
        stage_val = STG_PRD;
        if (val_last) state_n = S_PRD_WAIT;
      end
      S_PRD_WAIT: begin
        if (stage_rdy == STG_PRD) state_n = S_IDLE;
        else if (to_done)         state_n = S_ERR;
      end
      S_ASSOC_ISSUE: begin
        stage_val = STG_ASSOC;
        if (val_last) state_n = S_ASSOC_WAIT;
      end
      S_ASSOC_WAIT: begin
        if (stage_rdy == STG_ASSOC) state_n = assoc_new ? S_NEW_ISSUE : S_UPD_ISSUE;
        else if (to_done)           state_n = S_ERR;
      end
      S_UPD_ISSUE: begin
        stage_val = STG_UPD;
        if (val_last) state_n = S_UPD_WAIT;
      end
      S_UPD_WAIT: begin
        if (stage_rdy == STG_UPD) state_n = S_IDLE;
        else if (to_done)         state_n = S_ERR;
      end
      S_NEW_ISSUE: begin
        stage_val = STG_NEW;
        if (val_last) state_n = S_NEW_WAIT;
      end
      S_NEW_WAIT: begin
        if (stage_rdy == STG_NEW) state_n = S_IDLE;
        else if (to_done)         state_n = S_ERR;
      end
      S_ERR:   state_n = S_ERR;
      default: state_n = S_IDLE;
    endcase
  end

  // The timeout counter is parked at zero through ISSUE so each WAIT starts fresh.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      val_cnt <= '0;
      to_cnt  <= '0;
    end else if (is_issue) begin
      val_cnt <= val_last ? '0 : val_cnt + VW'(1);
      to_cnt  <= '0;
    end else if (is_wait) begin
      val_cnt <= '0;
      to_cnt  <= to_cnt + TW'(1);
    end else begin
      val_cnt <= '0;
      to_cnt  <= '0;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {obs_rk, obs_phi};
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      vlr          <= '0;
      alpha        <= '0;
      rk           <= '0;
      phi          <= '0;
      landmark_num <= '0;
    end else begin
      if (odo_hs) begin
        vlr   <= odo_vlr;
        alpha <= odo_alpha;
      end
      if (pop) {rk, phi} <= mem[rd_ptr];
      if (state == S_NEW_WAIT && stage_rdy == STG_NEW && landmark_num != '1)
        landmark_num <= landmark_num + LM_W'(1);
    end
  end

endmodule

// File: tb/tb_ekf_stage_sequencer.sv
// Scoreboard bench for ekf_stage_sequencer: acts as host and as the EKF core
// responder, checking every issued stage code and its operands in order.
module tb_ekf_stage_sequencer;

  localparam int DW      = 32;
  localparam int VAL_CYC = 2;
  localparam int TIMEOUT = 4096;
  localparam int LM_W    = 10;

  localparam logic [2:0] STG_PRD   = 3'd1;
  localparam logic [2:0] STG_NEW   = 3'd2;
  localparam logic [2:0] STG_UPD   = 3'd3;
  localparam logic [2:0] STG_ASSOC = 3'd4;

  typedef struct packed {
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic            clk = 1'b0;
  logic            sys_rst;
  logic            odo_val, odo_rdy;
  logic [DW-1:0]   odo_vlr, odo_alpha;
  logic            obs_val, obs_rdy;
  logic [DW-1:0]   obs_rk, obs_phi;
  logic [2:0]      stage_val, stage_rdy;
  logic            assoc_new;
  logic [DW-1:0]   vlr, alpha, rk, phi;
  logic [LM_W-1:0] landmark_num;
  logic            busy, timeout_err;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   resp_en  = 1'b1;
  int   resp_delay = 0;
  logic [2:0] prev_val, pend_code;
  int   hold_cnt, pend_cnt;
  bit   pend;

  ekf_stage_sequencer #(
    .DW(DW), .FIFO_AW(3), .VAL_CYC(VAL_CYC), .TIMEOUT(TIMEOUT), .LM_W(LM_W)
  ) dut (
    .clk(clk), .sys_rst(sys_rst),
    .odo_val(odo_val), .odo_rdy(odo_rdy), .odo_vlr(odo_vlr), .odo_alpha(odo_alpha),
    .obs_val(obs_val), .obs_rdy(obs_rdy), .obs_rk(obs_rk), .obs_phi(obs_phi),
    .stage_val(stage_val), .stage_rdy(stage_rdy), .assoc_new(assoc_new),
    .vlr(vlr), .alpha(alpha), .rk(rk), .phi(phi),
    .landmark_num(landmark_num), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic checkOps(input string tag);
    if (cur.code == STG_PRD) begin
      checkOutput({tag, "_vlr"}, vlr, cur.a);
      checkOutput({tag, "_alpha"}, alpha, cur.b);
    end else begin
      checkOutput({tag, "_rk"}, rk, cur.a);
      checkOutput({tag, "_phi"}, phi, cur.b);
    end
  endtask

  // Drives one odometry command or observation and records the stages it should cause.
  task automatic applyStimulus(input bit is_obs, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (is_obs) begin
      obs_val = 1'b1; obs_rk = a; obs_phi = b;
    end else begin
      odo_val = 1'b1; odo_vlr = a; odo_alpha = b;
    end
    for (int i = 0; i < 200; i++) begin
      if (is_obs ? obs_rdy : odo_rdy) break;
      @(negedge clk);
    end
    checkOutput(is_obs ? "obs_accept" : "odo_accept", 32'(is_obs ? obs_rdy : odo_rdy), 32'd1);
    @(posedge clk);
    if (is_obs) begin
      exp_q.push_back('{STG_ASSOC, a, b});
      exp_q.push_back('{(assoc_new ? STG_NEW : STG_UPD), a, b});
    end else begin
      exp_q.push_back('{STG_PRD, a, b});
    end
    #1;
    obs_val = 1'b0;
    odo_val = 1'b0;
    if (!is_obs) begin
      @(negedge clk);
      checkOutput("prd_latency", 32'(stage_val), 32'(STG_PRD));
    end
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    repeat (4) @(negedge clk);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    #3 sys_rst = 1'b1;
    #1;
    checkOutput("rst_async_stage_val", 32'(stage_val), 32'd0);
    checkOutput("rst_async_busy", 32'(busy), 32'd0);
    checkOutput("rst_async_vlr", vlr, 32'd0);
    checkOutput("rst_async_odo_rdy", 32'(odo_rdy), 32'd0);
    checkOutput("rst_async_obs_rdy", 32'(obs_rdy), 32'd0);
    checkOutput("rst_async_err", 32'(timeout_err), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2 sys_rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_release_odo_rdy", 32'(odo_rdy), 32'd1);
  endtask

  // Core responder and stage monitor: pops the scoreboard when a stage starts,
  // answers with stage_rdy resp_delay cycles after stage_val drops.
  initial begin
    stage_rdy = 3'd0;
    prev_val = 3'd0; pend_code = 3'd0;
    hold_cnt = 0; pend_cnt = 0; pend = 1'b0; have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (sys_rst) begin
        prev_val = 3'd0; hold_cnt = 0; pend = 1'b0; stage_rdy = 3'd0;
      end else begin
        stage_rdy = 3'd0;
        if (stage_val != 3'd0) begin
          if (prev_val == 3'd0) begin
            if (exp_q.size() == 0) begin
              have_cur = 1'b0;
              checkOutput("unexpected_stage", 32'(stage_val), 32'd0);
            end else begin
              cur = exp_q.pop_front();
              have_cur = 1'b1;
              checkOutput("stage_code", 32'(stage_val), 32'(cur.code));
              checkOps("issue");
            end
            hold_cnt = 1;
          end else begin
            hold_cnt++;
          end
        end else if (prev_val != 3'd0) begin
          checkOutput("val_cycles", 32'(hold_cnt), 32'(VAL_CYC));
          if (have_cur) checkOps("stable");
          if (resp_en) begin
            pend = 1'b1; pend_code = prev_val; pend_cnt = resp_delay;
          end
        end
        if (pend) begin
          if (pend_cnt == 0) begin
            stage_rdy = pend_code;
            pend = 1'b0;
          end else begin
            pend_cnt--;
          end
        end
        prev_val = stage_val;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    sys_rst = 1'b1;
    odo_val = 1'b0; odo_vlr = '0; odo_alpha = '0;
    obs_val = 1'b0; obs_rk = '0; obs_phi = '0;
    assoc_new = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("init_stage_val", 32'(stage_val), 32'd0);
    checkOutput("init_odo_rdy", 32'(odo_rdy), 32'd0);
    checkOutput("init_obs_rdy", 32'(obs_rdy), 32'd0);
    checkOutput("init_busy", 32'(busy), 32'd0);
    checkOutput("init_landmark", 32'(landmark_num), 32'd0);
    checkOutput("init_err", 32'(timeout_err), 32'd0);
    sys_rst = 1'b0;
    @(negedge clk);
    checkOutput("init_odo_rdy_after", 32'(odo_rdy), 32'd1);

    // Plain predict with a slow core.
    $display("[TB] predict with 50-cycle core latency");
    resp_delay = 50;
    applyStimulus(1'b0, 32'h0010_0000, 32'h0002_0000);
    waitIdle("prd_basic");

    // Reset in the middle of PRD_WAIT with an observation queued.
    $display("[TB] reset during PRD_WAIT");
    applyStimulus(1'b0, 32'h0000_1234, 32'h0000_5678);
    for (int i = 0; i < 20 && stage_val != 3'd0; i++) @(negedge clk);
    applyStimulus(1'b1, 32'h0000_0abc, 32'h0000_0def);
    applyReset();
    repeat (5) @(negedge clk);
    checkOutput("fifo_empty_after_rst", 32'(busy), 32'd0);
    checkOutput("obs_rdy_after_rst", 32'(obs_rdy), 32'd1);

    // Single observation resolved as a new landmark, with ASSOC latency check.
    $display("[TB] observation to NEW landmark");
    resp_delay = 3;
    assoc_new = 1'b1;
    applyStimulus(1'b1, 32'd10730636, -32'sd359159);
    @(negedge clk);
    checkOutput("pop_lat0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("pop_lat1_busy", 32'(busy), 32'd1);
    checkOutput("pop_lat1_val", 32'(stage_val), 32'd0);
    @(negedge clk);
    checkOutput("assoc_latency", 32'(stage_val), 32'(STG_ASSOC));
    waitIdle("new_lm");
    checkOutput("landmark_after_new", 32'(landmark_num), 32'd1);

    // Two full fills behind a slow predict; a ninth push is refused each time.
    assoc_new = 1'b0;
    for (int f = 0; f < 2; f++) begin
      $display("[TB] fill %0d of observation FIFO", f);
      resp_delay = 30;
      applyStimulus(1'b0, 32'h0100_0000 + 32'(f), 32'h0000_0100);
      for (int k = 0; k < 8; k++) begin
        ra = $urandom; rb = $urandom;
        applyStimulus(1'b1, ra, rb);
      end
      resp_delay = 1;
      @(negedge clk);
      obs_val = 1'b1; obs_rk = 32'hdead_beef; obs_phi = 32'h0bad_f00d;
      checkOutput("obs_rdy_full", 32'(obs_rdy), 32'd0);
      @(negedge clk);
      checkOutput("obs_rdy_full_hold", 32'(obs_rdy), 32'd0);
      obs_val = 1'b0;
      waitIdle("drain");
    end
    checkOutput("landmark_after_upd", 32'(landmark_num), 32'd1);

    // Odometry and observation offered together in IDLE.
    $display("[TB] simultaneous odometry and observation");
    resp_delay = 2;
    @(negedge clk);
    odo_val = 1'b1; odo_vlr = 32'h0003_0000; odo_alpha = 32'hfffe_0000;
    obs_val = 1'b1; obs_rk = 32'h0007_7777; obs_phi = 32'h0000_0042;
    checkOutput("prio_odo_rdy", 32'(odo_rdy), 32'd1);
    checkOutput("prio_obs_rdy", 32'(obs_rdy), 32'd1);
    @(posedge clk);
    exp_q.push_back('{STG_PRD, 32'h0003_0000, 32'hfffe_0000});
    exp_q.push_back('{STG_ASSOC, 32'h0007_7777, 32'h0000_0042});
    exp_q.push_back('{STG_UPD, 32'h0007_7777, 32'h0000_0042});
    #1;
    odo_val = 1'b0; obs_val = 1'b0;
    @(negedge clk);
    checkOutput("prio_prd_first", 32'(stage_val), 32'(STG_PRD));
    waitIdle("prio");

    // Core never answers ASSOC: sticky timeout.
    $display("[TB] ASSOC timeout");
    resp_en = 1'b0;
    applyStimulus(1'b1, 32'h0000_1111, 32'h0000_2222);
    for (int i = 0; i < 20 && stage_val != STG_ASSOC; i++) @(negedge clk);
    checkOutput("to_assoc_seen", 32'(stage_val), 32'(STG_ASSOC));
    for (int i = 0; i < 20 && stage_val != 3'd0; i++) @(negedge clk);
    repeat (TIMEOUT - 1) @(negedge clk);
    checkOutput("to_err_early", 32'(timeout_err), 32'd0);
    @(negedge clk);
    checkOutput("to_err_set", 32'(timeout_err), 32'd1);
    checkOutput("to_stage_val", 32'(stage_val), 32'd0);
    checkOutput("to_busy", 32'(busy), 32'd1);
    odo_val = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("to_odo_rdy", 32'(odo_rdy), 32'd0);
    checkOutput("to_err_sticky", 32'(timeout_err), 32'd1);
    odo_val = 1'b0;
    resp_en = 1'b1;
    applyReset();
    checkOutput("to_err_cleared", 32'(timeout_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
